// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 packet router datapath.
//   DATA_W        : byte width of the router datapath.
//   ADDR_INVALID  : header address code that selects no output port.
//   ADDR_*/LEN_*  : bit positions of the header fields {len[7:2], addr[1:0]}.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int         DATA_W       = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Header field slices
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;

endpackage

// File: rtl/router_parity_chk.sv
// -----------------------------------------------------------------------------
// router_parity_chk
// Running XOR parity over header and payload bytes, capture of the packet's
// trailing parity byte, and the mismatch flag.
// Only instantiated when ROUTER_REG_PARITY_CHK_EN is defined.
//
// Ports:
//   i_clock        : system clock, all updates on posedge
//   i_resetn       : synchronous active-high reset
//   i_detect_add   : FSM DECODE_ADDRESS, starts a new packet
//   i_lfd_state    : FSM LOAD_FIRST_DATA, header byte enters parity
//   i_ld_state     : FSM LOAD_DATA
//   i_pkt_valid    : high on header/payload bytes, low on the parity byte
//   i_full_state   : FSM FIFO_FULL_STATE
//   i_parity_done  : parity byte has been forwarded
//   i_header_byte  : latched header byte
//   i_data_in      : input byte
//   o_err          : parity mismatch flag
// -----------------------------------------------------------------------------
module router_parity_chk #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_detect_add,
    input  logic              i_lfd_state,
    input  logic              i_ld_state,
    input  logic              i_pkt_valid,
    input  logic              i_full_state,
    input  logic              i_parity_done,
    input  logic [DATA_W-1:0] i_header_byte,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              o_err
);

    logic [DATA_W-1:0] r_int_parity;
    logic [DATA_W-1:0] r_pkt_parity;
    logic              r_err;

    always_ff @(posedge i_clock) begin
        if (i_resetn) begin
            r_int_parity <= '0;
            r_pkt_parity <= '0;
            r_err        <= 1'b0;
        end else begin
            // The parity byte itself (pkt_valid low) never enters the running XOR.
            if (i_detect_add)
                r_int_parity <= '0;
            else if (i_lfd_state)
                r_int_parity <= r_int_parity ^ i_header_byte;
            else if (i_ld_state && i_pkt_valid && !i_full_state)
                r_int_parity <= r_int_parity ^ i_data_in;

            if (i_detect_add)
                r_pkt_parity <= '0;
            else if (i_ld_state && !i_pkt_valid)
                r_pkt_parity <= i_data_in;

            // Compared one cycle after parity_done so pkt_parity is settled.
            if (i_detect_add)
                r_err <= 1'b0;
            else if (i_parity_done)
                r_err <= (r_int_parity != r_pkt_parity);
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/router_reg.sv
// -----------------------------------------------------------------------------
// router_reg
// Datapath register stage of the 1x3 router: latches the header, forwards
// header/payload/parity bytes to the FIFO write bus, and parks the byte that
// arrives while the selected FIFO is full.
//
// Build option: ROUTER_REG_PARITY_CHK_EN -- when defined, parity is checked
// and o_err reports mismatches; when undefined, o_err is tied low.
//
// Ports:
//   i_clock            : system clock, all updates on posedge
//   i_resetn           : synchronous active-high reset
//   i_pkt_valid        : high on header/payload bytes, low on parity byte
//   i_data_in          : input byte, header = {len[7:2], addr[1:0]}
//   i_fifo_full        : selected FIFO is full
//   i_rst_int_reg      : clears o_low_packet_valid
//   i_detect_add       : FSM DECODE_ADDRESS
//   i_ld_state         : FSM LOAD_DATA
//   i_lfd_state        : FSM LOAD_FIRST_DATA
//   i_laf_state        : FSM LOAD_AFTER_FULL
//   i_full_state       : FSM FIFO_FULL_STATE
//   o_parity_done      : parity byte has been forwarded
//   o_low_packet_valid : pkt_valid fell while in LOAD_DATA
//   o_dout             : byte written to the FIFO
//   o_err              : parity mismatch flag
// -----------------------------------------------------------------------------
module router_reg #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_pkt_valid,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_fifo_full,
    input  logic              i_rst_int_reg,
    input  logic              i_detect_add,
    input  logic              i_ld_state,
    input  logic              i_lfd_state,
    input  logic              i_laf_state,
    input  logic              i_full_state,
    output logic              o_parity_done,
    output logic              o_low_packet_valid,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_err
);

    import router_pkg::*;

    logic [DATA_W-1:0] r_header_byte;
    logic [DATA_W-1:0] r_full_byte;
    logic [DATA_W-1:0] r_dout;
    logic              r_parity_done;
    logic              r_low_packet_valid;
    logic              w_addr_ok;
    logic              w_err;

    assign w_addr_ok = (i_data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID);

    always_ff @(posedge i_clock) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of statement order.
        if (i_resetn) begin
            r_header_byte      <= '0;
            r_full_byte        <= '0;
            r_dout             <= '0;
            r_parity_done      <= 1'b0;
            r_low_packet_valid <= 1'b0;
        end else begin
            // A header addressing no port is dropped; the old header is kept.
            if (i_detect_add && i_pkt_valid && w_addr_ok)
                r_header_byte <= i_data_in;

            if (i_lfd_state)
                r_dout <= r_header_byte;
            else if (i_ld_state && !i_fifo_full)
                r_dout <= i_data_in;
            else if (i_laf_state)
                r_dout <= r_full_byte;

            // Byte arriving while the FIFO is full is replayed in LOAD_AFTER_FULL.
            if (i_ld_state && i_fifo_full)
                r_full_byte <= i_data_in;

            if (i_rst_int_reg)
                r_low_packet_valid <= 1'b0;
            else if (i_ld_state && !i_pkt_valid)
                r_low_packet_valid <= 1'b1;

            // Parity byte forwarded directly, or replayed after a full stall.
            if (i_detect_add)
                r_parity_done <= 1'b0;
            else if ((i_ld_state && !i_fifo_full && !i_pkt_valid) ||
                     (i_laf_state && r_low_packet_valid && !r_parity_done))
                r_parity_done <= 1'b1;
        end
    end

`ifdef ROUTER_REG_PARITY_CHK_EN
    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_parity_chk (
        .i_clock       (i_clock),
        .i_resetn      (i_resetn),
        .i_detect_add  (i_detect_add),
        .i_lfd_state   (i_lfd_state),
        .i_ld_state    (i_ld_state),
        .i_pkt_valid   (i_pkt_valid),
        .i_full_state  (i_full_state),
        .i_parity_done (r_parity_done),
        .i_header_byte (r_header_byte),
        .i_data_in     (i_data_in),
        .o_err         (w_err)
    );
`else
    // FIFO_FULL_STATE only gates the parity accumulator, absent in this build.
    logic w_unused_full_state;
    assign w_unused_full_state = i_full_state;
    assign w_err = 1'b0;
`endif

    assign o_dout             = r_dout;
    assign o_parity_done      = r_parity_done;
    assign o_low_packet_valid = r_low_packet_valid;
    assign o_err              = w_err;

endmodule

// File: tb/tb_router_reg.sv
// -----------------------------------------------------------------------------
// tb_router_reg
// Directed bench for router_reg. The driver applies one cycle of strobes per
// step and queues the hand-computed outputs expected after that edge; an
// independent monitor pops the queue on each falling edge and compares.
// -----------------------------------------------------------------------------
module tb_router_reg;

`ifdef ROUTER_REG_PARITY_CHK_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       rst_int_reg;
    logic       detect_add;
    logic       ld_state;
    logic       lfd_state;
    logic       laf_state;
    logic       full_state;
    logic       parity_done;
    logic       low_packet_valid;
    logic [7:0] dout;
    logic       err;

    typedef struct {
        string      name;
        logic [7:0] dout;
        logic       err;
        logic       pd;
        logic       lpv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic done     = 1'b0;
    logic drained  = 1'b0;

    router_reg #(.DATA_W(8)) dut (
        .i_clock            (clk),
        .i_resetn           (resetn),
        .i_pkt_valid        (pkt_valid),
        .i_data_in          (data_in),
        .i_fifo_full        (fifo_full),
        .i_rst_int_reg      (rst_int_reg),
        .i_detect_add       (detect_add),
        .i_ld_state         (ld_state),
        .i_lfd_state        (lfd_state),
        .i_laf_state        (laf_state),
        .i_full_state       (full_state),
        .o_parity_done      (parity_done),
        .o_low_packet_valid (low_packet_valid),
        .o_dout             (dout),
        .o_err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // Monitor: outputs are registered, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".dout"}, {24'd0, dout}, {24'd0, e.dout});
            check({e.name, ".err"},  {31'd0, err}, {31'd0, e.err});
            check({e.name, ".parity_done"}, {31'd0, parity_done}, {31'd0, e.pd});
            check({e.name, ".low_packet_valid"}, {31'd0, low_packet_valid}, {31'd0, e.lpv});
        end else if (done && !drained) begin
            check("queue_drained", exp_q.size(), 0);
            drained = 1'b1;
        end
    end

    task automatic step(
        input logic rst, input logic da, input logic lfd, input logic ld,
        input logic laf, input logic fst, input logic rint, input logic pv,
        input logic ff, input logic [7:0] din, input string nm,
        input logic [7:0] e_dout, input logic e_err, input logic e_pd, input logic e_lpv
    );
        exp_t e;
        @(negedge clk);
        resetn      = rst;
        detect_add  = da;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = fst;
        rst_int_reg = rint;
        pkt_valid   = pv;
        fifo_full   = ff;
        data_in     = din;
        @(posedge clk);
        #1;
        e.name = nm;
        e.dout = e_dout;
        e.err  = e_err;
        e.pd   = e_pd;
        e.lpv  = e_lpv;
        exp_q.push_back(e);
    endtask

    initial begin
        resetn      = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        data_in     = 8'h00;

        //   rst da lfd ld laf fst rint pv ff din     name            dout  err pd lpv
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, "reset",        8'h00, 0, 0, 0);

        // Good packet: 0x0E ^ 0x24 ^ 0x81 ^ 0x09 = 0xA2
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h0E, "g_decode",     8'h00, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h24, "g_lfd",        8'h0E, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h24, "g_ld0",        8'h24, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h81, "g_ld1",        8'h81, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h09, "g_ld2",        8'h09, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'hA2, "g_parity",     8'hA2, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, "g_err",        8'hA2, 0, 1, 1);

        // rst_int_reg clears only low_packet_valid
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, "rint_clr",     8'hA2, 0, 1, 0);

        // Bad packet: parity byte 0x5D
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h0E, "b_decode",     8'hA2, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h24, "b_lfd",        8'h0E, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h24, "b_ld0",        8'h24, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h81, "b_ld1",        8'h81, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h09, "b_ld2",        8'h09, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h5D, "b_parity",     8'h5D, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, "b_err",        8'h5D, PE, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, "b_err_hold",   8'h5D, PE, 1, 1);

        // Invalid address 0x0F: detect_add clears err/parity_done, header kept at 0x0E
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h0F, "inv_decode",   8'h5D, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1, 1, 0, 8'h00, "inv_lfd",      8'h0E, 0, 0, 0);

        // FIFO full on a payload byte: 0x55 parked, replayed in LOAD_AFTER_FULL
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h24, "ff_ld",        8'h24, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 1, 8'h55, "ff_hold",      8'h24, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 1, 8'h81, "ff_wait",      8'h24, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00, "ff_laf",       8'h55, 0, 0, 0);

        // FIFO full on the parity byte: 0x0E ^ 0x24 ^ 0x55 = 0x7F
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h7F, "fp_full",      8'h55, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h7F, "fp_wait",      8'h55, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00, "fp_laf",       8'h7F, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, "fp_err",       8'h7F, 0, 1, 1);

        // Reset mid-packet, then a clean restart
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h05, "r_decode",     8'h7F, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h33, "r_lfd",        8'h05, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h33, "r_ld",         8'h33, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h99, "r_reset",      8'h00, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00, "r_lfd_clean",  8'h00, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h06, "r2_decode",    8'h00, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00, "r2_lfd",       8'h06, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h06, "r2_parity",    8'h06, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, "r2_err",       8'h06, 0, 1, 1);

        // Bounded drain: the monitor flags anything left unchecked.
        repeat (3) @(negedge clk);
        done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        if (!drained) begin
            $display("FAIL queue_drain_timeout: got %0d entries, expected 0", exp_q.size());
            $fatal(1, "monitor did not drain");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 packet router, between the input port and the three output FIFOs.
- Latches the header, forwards header/payload/parity bytes to the FIFO write bus, and holds the byte that arrives while the FIFO is full.
- Accumulates running XOR parity and compares it with the packet's trailing parity byte, raising err on mismatch.
- State strobes come from the router FSM; fifo_full comes from the synchronizer.

Parameters:
- DATA_W, 8, byte width of data_in/dout and all internal byte registers.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- resetn  in  1  synchronous, active-high reset: when 1 at a posedge, all registers clear. Port name kept as the codebase names it; polarity and synchronicity are fixed.
- pkt_valid  in  1  high while header/payload bytes are on data_in; low on the parity byte.
- data_in  in  DATA_W  input byte; header layout is {payload_len[7:2], addr[1:0]}.
- fifo_full  in  1  selected FIFO is full.
- rst_int_reg  in  1  clears low_packet_valid.
- detect_add  in  1  FSM DECODE_ADDRESS state.
- ld_state  in  1  FSM LOAD_DATA state.
- lfd_state  in  1  FSM LOAD_FIRST_DATA state.
- laf_state  in  1  FSM LOAD_AFTER_FULL state.
- full_state  in  1  FSM FIFO_FULL_STATE.
- parity_done  out  1  parity byte has been captured/forwarded.
- low_packet_valid  out  1  pkt_valid fell while in LOAD_DATA.
- dout  out  DATA_W  byte written to FIFO.
- err  out  1  parity mismatch flag.

Behaviour:
- Reset: dout, err, parity_done, low_packet_valid, header_byte, full_byte, int_parity and pkt_parity all go to 0.
- Priority when several conditions hold: reset first, then the conditions listed in each item, in order.
- header_byte: loads data_in when detect_add && pkt_valid && data_in[1:0]!=2'b11; otherwise holds.
- dout (one-cycle latency):
  - lfd_state: loads header_byte.
  - else ld_state && !fifo_full: loads data_in.
  - else laf_state: loads full_byte.
  - otherwise holds.
- full_byte: loads data_in when ld_state && fifo_full.
- low_packet_valid: rst_int_reg clears it; else ld_state && !pkt_valid sets it; otherwise holds.
- parity_done:
  - detect_add clears it.
  - Else it is set by (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_packet_valid && !parity_done).
  - Otherwise holds.
- int_parity:
  - detect_add clears it.
  - lfd_state: ^= header_byte.
  - ld_state && pkt_valid && !full_state: ^= data_in.
  - The parity byte itself is excluded.
- pkt_parity: detect_add clears it; ld_state && !pkt_valid loads data_in.
- err:
  - detect_add clears it.
  - Else, when parity_done==1 at a posedge, err <= (int_parity != pkt_parity). Valid one cycle after parity_done rises.
  - Otherwise holds.
- Reset mid-packet: everything returns to reset values; the next detect_add starts cleanly.
- Address 2'b11 header: header_byte is not updated.

Optional Feature:
- ROUTER_REG_PARITY_CHK_EN.
- Defined: int_parity, pkt_parity and err behave as above.
- Undefined: the parity registers are omitted and err is tied to 0. parity_done and low_packet_valid are unchanged.

Decomposition:
- Shared package router_pkg holds DATA_W, the ADDR_INVALID constant 2'b11, and the header field slices (addr [1:0], len [7:2]).
- One natural sub-module, router_parity_chk: int_parity, pkt_parity and err logic.
- Byte registers and flags stay in router_reg.

Test Plan:
- Reset: assert resetn for 1 cycle -> dout=0x00, err=0, parity_done=0, low_packet_valid=0.
- Good packet:
  - Stimulus: detect_add with header 0x0E (len 3, addr 2); lfd; ld with 0x24, 0x81, 0x09 (pkt_valid=1); ld with pkt_valid=0 and parity 0xA2.
  - Response: dout sequence 0x0E, 0x24, 0x81, 0x09, 0xA2; low_packet_valid=1 and parity_done=1 after the parity edge; err=0 one cycle later.
- Bad packet: same payload, parity byte 0x5D (~0xA2) -> err=1 one cycle after parity_done; the next detect_add clears err and parity_done.
- FIFO full:
  - Stimulus: in ld_state with fifo_full=1, data_in=0x55.
  - Response: dout holds its previous value; then laf_state -> dout=0x55.
  - laf_state with low_packet_valid=1 and parity_done=0 sets parity_done.
- Invalid address: detect_add with pkt_valid=1 and header 0x0F -> header_byte keeps its previous value; the following lfd outputs the old header.
- rst_int_reg: pulse while low_packet_valid=1 -> low_packet_valid clears the next cycle; other outputs unaffected.
